// File: rtl/xge_tx_arb_pkg.sv
// Shared types and constants for the xge_mac transmit-side packet arbiter.
package xge_tx_arb_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int PKT_CNT_W   = 16;
    localparam int MOD_W       = 3;

    typedef logic [MOD_W-1:0] pkt_mod_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } arb_state_e;

endpackage

// File: rtl/xge_rr_pick.sv
// Combinational round-robin pick: rotate requests so rr_ptr sits at bit 0,
// take the lowest set bit, then rotate the index back.
module xge_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int GRANT_W = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GRANT_W-1:0] rr_ptr,
    output logic               valid,
    output logic [GRANT_W-1:0] index
);

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic [GRANT_W-1:0]   offset;
    logic [GRANT_W:0]     index_sum;

    // Doubling the vector turns the rotate into a plain right shift.
    assign req_dbl = {req, req};
    assign req_rot = NUM_REQ'(req_dbl >> rr_ptr);
    assign valid   = |req;

    always_comb begin
        offset = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                offset = GRANT_W'(i);
            end
        end
        index_sum = {1'b0, offset} + {1'b0, rr_ptr};
        if (index_sum >= (GRANT_W+1)'(NUM_REQ)) begin
            index_sum = index_sum - (GRANT_W+1)'(NUM_REQ);
        end
        index = index_sum[GRANT_W-1:0];
    end

endmodule

// File: rtl/xge_tx_arbiter.sv
// Packet-granular round-robin arbiter feeding the xge_mac pkt_tx interface;
// the grant is locked from SOP to EOP and all MAC-facing outputs are registered.
module xge_tx_arbiter
    import xge_tx_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int GRANT_W = $clog2(NUM_REQ),
    parameter int CNT_W   = PKT_CNT_W
) (
    input  logic                     clk_156m25,
    input  logic                     reset_156m25_n,
    input  logic [NUM_REQ-1:0]       req_tx_val,
    input  logic [NUM_REQ-1:0]       req_tx_sop,
    input  logic [NUM_REQ-1:0]       req_tx_eop,
    input  logic [NUM_REQ*MOD_W-1:0] req_tx_mod,
    input  logic [NUM_REQ*64-1:0]    req_tx_data,
    output logic [NUM_REQ-1:0]       req_tx_rdy,
    output logic [63:0]              pkt_tx_data,
    output logic                     pkt_tx_val,
    output logic                     pkt_tx_sop,
    output logic                     pkt_tx_eop,
    output pkt_mod_t                 pkt_tx_mod,
    input  logic                     pkt_tx_full,
    output logic [GRANT_W-1:0]       grant_id,
    output logic                     busy,
    output logic                     sop_err,
    output logic [CNT_W-1:0]         pkt_sent_cnt
);

    arb_state_e         state_reg;
    logic [GRANT_W-1:0] rr_ptr_reg;
    logic               sop_seen_reg;

    logic               pick_valid;
    logic [GRANT_W-1:0] pick_idx;
    logic [GRANT_W-1:0] next_ptr;

    logic               g_val, g_sop, g_eop;
    pkt_mod_t           g_mod;
    logic [63:0]        g_data;
    logic               accept, drop, fwd;

    xge_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .GRANT_W (GRANT_W)
    ) u_pick (
        .req    (req_tx_val),
        .rr_ptr (rr_ptr_reg),
        .valid  (pick_valid),
        .index  (pick_idx)
    );

    always_comb begin
        g_val  = 1'b0;
        g_sop  = 1'b0;
        g_eop  = 1'b0;
        g_mod  = '0;
        g_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == GRANT_W'(i)) begin
                g_val  = req_tx_val[i];
                g_sop  = req_tx_sop[i];
                g_eop  = req_tx_eop[i];
                g_mod  = req_tx_mod[i*MOD_W +: MOD_W];
                g_data = req_tx_data[i*64 +: 64];
            end
        end
    end

    assign busy     = (state_reg == ST_XFER);
    assign accept   = busy && g_val && !pkt_tx_full;
    // A grant must open with SOP; anything before it is discarded.
    assign drop     = accept && !sop_seen_reg && !g_sop;
    assign fwd      = accept && !drop;
    assign next_ptr = (grant_id == GRANT_W'(NUM_REQ - 1)) ? '0 : grant_id + GRANT_W'(1);

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rdy
            assign req_tx_rdy[gi] = busy && (grant_id == GRANT_W'(gi)) && !pkt_tx_full;
        end
    endgenerate

    always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
        if (!reset_156m25_n) begin
            state_reg    <= ST_IDLE;
            rr_ptr_reg   <= '0;
            sop_seen_reg <= 1'b0;
            grant_id     <= '0;
            pkt_tx_val   <= 1'b0;
            pkt_tx_sop   <= 1'b0;
            pkt_tx_eop   <= 1'b0;
            pkt_tx_mod   <= '0;
            pkt_tx_data  <= '0;
            sop_err      <= 1'b0;
            pkt_sent_cnt <= '0;
        end else begin
            pkt_tx_val  <= fwd;
            pkt_tx_sop  <= fwd && g_sop;
            pkt_tx_eop  <= fwd && g_eop;
            pkt_tx_mod  <= (fwd && g_eop) ? g_mod : '0;
            pkt_tx_data <= fwd ? g_data : '0;
            sop_err     <= drop;

            case (state_reg)
                ST_IDLE: begin
                    if (pick_valid) begin
                        grant_id     <= pick_idx;
                        sop_seen_reg <= 1'b0;
                        state_reg    <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (fwd) begin
                        sop_seen_reg <= 1'b1;
                        if (g_eop) begin
                            sop_seen_reg <= 1'b0;
                            rr_ptr_reg   <= next_ptr;
                            pkt_sent_cnt <= pkt_sent_cnt + CNT_W'(1);
                            state_reg    <= ST_IDLE;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/xge_tx_arbiter.md
# xge_tx_arbiter

Packet-granular round-robin arbiter that shares the single xge_mac transmit packet interface (pkt_tx_*) among NUM_REQ packet sources in the 156.25 MHz core domain. It sits between the requesters and the MAC, and locks the grant from SOP through EOP so packets are never interleaved. It honours the MAC's pkt_tx_full back-pressure and drives all MAC-facing signals from registers.

## Interface
- NUM_REQ, 4: number of requesters (2..8)
- GRANT_W, $clog2(NUM_REQ): grant index width
- clk_156m25  in  1  core clock
- reset_156m25_n  in  1  asynchronous active-low reset
- req_tx_val  in  NUM_REQ  per-requester word valid
- req_tx_sop  in  NUM_REQ  per-requester start of packet
- req_tx_eop  in  NUM_REQ  per-requester end of packet
- req_tx_mod  in  NUM_REQ×3  valid byte count on EOP word (0 = 8 bytes)
- req_tx_data  in  NUM_REQ×64  packet data
- req_tx_rdy  out  NUM_REQ  word accepted when val && rdy
- pkt_tx_data  out  64  to MAC
- pkt_tx_val, pkt_tx_sop, pkt_tx_eop  out  1 each  to MAC
- pkt_tx_mod  out  3  to MAC
- pkt_tx_full  in  1  MAC TX FIFO full
- grant_id  out  GRANT_W  current/last grantee
- busy  out  1  high in XFER
- sop_err  out  1  one-cycle pulse: granted first word lacked SOP, word dropped
- pkt_sent_cnt  out  16  packets forwarded, wraps at 0xFFFF→0

## Operation
- States: IDLE, XFER.
- IDLE:
  - Round-robin pick among req_tx_val, starting at rr_ptr and searching upward modulo NUM_REQ.
  - If any request is pending: register grant_id and go to XFER. No words are accepted in IDLE.
- XFER:
  - req_tx_rdy[grant_id] = !pkt_tx_full. All other rdy bits are 0.
  - Accepted word is registered onto pkt_tx_* next cycle, with pkt_tx_val high for exactly one cycle.
  - pkt_tx_mod = req_tx_mod on EOP words, 0 otherwise.
- First accepted word of a grant with sop=0:
  - Word is dropped, sop_err pulses, and the arbiter stays in XFER awaiting SOP.
- SOP received mid-packet (before EOP):
  - Forwarded as-is. The arbiter does not repair the framing.
- EOP accepted:
  - rr_ptr ← grant_id+1 mod NUM_REQ, pkt_sent_cnt increments, next state IDLE.
- Single-word packet (sop and eop both set): forwarded as one word, with the same EOP handling.
- pkt_tx_full high: no acceptance, pkt_tx_val low next cycle, grant held indefinitely.
- Reset, including mid-packet:
  - All outputs 0, state IDLE, rr_ptr 0, pkt_sent_cnt 0.
  - A truncated packet is not completed; the MAC resets in the same domain.

## Timing
- Output latency: 1 cycle from accept (val && rdy at edge N) to pkt_tx_val at N+1.
- pkt_tx_full sampling:
  - rdy is combinational from pkt_tx_full, so at most one word reaches the MAC in the cycle after full rises.
  - The MAC FIFO's almost-full margin covers this word.
- Grant latency: request seen in IDLE at edge N → rdy possible from cycle N+1.
- Packet gap: minimum 1 idle cycle on pkt_tx_val between packets (the IDLE cycle). Back-to-back packets from different requesters are separated by exactly 1 cycle when full=0.
- Fairness:
  - With all requesters continuously pending, grants rotate 0,1,…,NUM_REQ-1,0.
  - No requester waits more than NUM_REQ-1 packets.
- grant_id holds its value in IDLE until the next grant.

## Structure
- Package xge_tx_arb_pkg:
  - Default NUM_REQ.
  - State enum (IDLE, XFER).
  - 3-bit mod typedef.
  - Counter width constant (16).
- Sub-module xge_rr_pick: combinational rotate-priority-rotate pick (req vector, rr_ptr → valid, index).
- Top holds the FSM, output registers and counters.

## Test plan
- Only requester 2 sends a 3-word packet (sop on w0, eop on w2, mod=5), full=0 → pkt_tx words on cycles N+1..N+3, eop with mod=5, grant_id=2, pkt_sent_cnt=1.
- All 4 requesters pending single-word packets continuously → grant order 0,1,2,3,0; 1 idle cycle between output words.
- pkt_tx_full held high for 5 cycles mid-packet → rdy=0 and no pkt_tx_val for those cycles; data order intact; grant unchanged.
- Granted requester 1 presents first word with sop=0 (data 0xDEAD) → sop_err pulses once; word absent on pkt_tx_data; next sop word forwarded normally.
- Assert reset_156m25_n low asynchronously mid-packet → all outputs 0 immediately; after release, requester 0 granted first.
- Run 65536 single-word packets → pkt_sent_cnt wraps to 0.
